grid_row_framer: RTL and testbench



---
 rtl/grid_pkg.sv | 10 +
 rtl/grid_byte_classifier.sv | 16 +
 rtl/grid_row_framer.sv | 91 +++++++++
 tb/tb_grid_row_framer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared ASCII constants, byte classes and framer states for the roll-grid framer
package grid_pkg;
  localparam logic [7:0] ASCII_ROP   = 8'h40;
  localparam logic [7:0] ASCII_EMPTY = 8'h2E;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_NUL   = 8'h00;
  typedef enum logic [2:0] {CLS_CELL0, CLS_CELL1, CLS_EOL, CLS_SKIP, CLS_EOI, CLS_BAD} byte_class_t;
  typedef enum logic [1:0] {ST_FIRST_ROW, ST_ROW, ST_DONE, ST_ERROR} framer_state_t;
endpackage

// File: rtl/grid_byte_classifier.sv
// grid_byte_classifier: maps an ASCII byte to its grid byte class
//   byte_i : input byte
//   cls_o  : byte class
module grid_byte_classifier
  import grid_pkg::*;
(
  input  logic [7:0]  byte_i,
  output byte_class_t cls_o
);
  always_comb
    cls_o = byte_i == ASCII_ROP   ? CLS_CELL1 :
            byte_i == ASCII_EMPTY ? CLS_CELL0 :
            byte_i == ASCII_LF    ? CLS_EOL   :
            byte_i == ASCII_CR    ? CLS_SKIP  :
            byte_i == ASCII_NUL   ? CLS_EOI   : CLS_BAD;
endmodule

// File: rtl/grid_row_framer.sv
// grid_row_framer: frames an ASCII grid byte stream into tagged roll/empty cells
//   clk, rst_n            : clock, async active-low reset
//   byte_valid_i/data_i   : input byte strobe and data
//   cell_valid/rop/last_o : cell strobe, roll flag, end-of-row tag
//   grid_done_o           : end-of-grid pulse
//   col_count_o/row_count_o : latched width, completed rows
//   format_error_o        : sticky malformed-input flag
module grid_row_framer
  import grid_pkg::*;
#(
  parameter int MAX_COLS  = 160,
  parameter int MAX_ROWS  = 160,
  parameter int COL_WIDTH = $clog2(MAX_COLS+1),
  parameter int ROW_WIDTH = $clog2(MAX_ROWS+1)
)(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic                 cell_valid_o,
  output logic                 cell_rop_o,
  output logic                 cell_last_o,
  output logic                 grid_done_o,
  output logic [COL_WIDTH-1:0] col_count_o,
  output logic [ROW_WIDTH-1:0] row_count_o,
  output logic                 format_error_o
);
  byte_class_t cls;
  framer_state_t state_q, state_d;
  logic pend_q, pend_d, pcell_q, pcell_d;
  logic [COL_WIDTH-1:0] col_idx_q, col_idx_d, col_count_d, lim;
  logic [ROW_WIDTH-1:0] row_count_d;
  logic cell_valid_d, cell_rop_d, cell_last_d, grid_done_d, format_error_d;
  logic first, g, is_cell, cell_ok, eol_ok, term_ok, bad;
  grid_byte_classifier u_cls (.byte_i(byte_data_i), .cls_o(cls));
  // A cell byte with nothing pending yet, or an LF that closes a row, is decided
  // against the width limit: MAX_COLS while measuring, the latched width afterwards.
  assign first   = state_q == ST_FIRST_ROW;
  assign g       = byte_valid_i && (first || state_q == ST_ROW);
  assign lim     = first ? COL_WIDTH'(MAX_COLS) : col_count_o;
  assign is_cell = cls == CLS_CELL0 || cls == CLS_CELL1;
  assign cell_ok = is_cell && col_idx_q != lim;
  assign eol_ok  = cls == CLS_EOL && pend_q &&
                   (first || (col_idx_q == col_count_o && row_count_o != ROW_WIDTH'(MAX_ROWS)));
  // An empty line (LF with nothing pending) terminates exactly like NUL.
  assign term_ok = (cls == CLS_EOI || (cls == CLS_EOL && !pend_q)) && col_idx_q == '0;
  assign bad     = g && !(cls == CLS_SKIP || cell_ok || eol_ok || term_ok);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q        <= ST_FIRST_ROW;
      pend_q         <= 1'b0;
      pcell_q        <= 1'b0;
      col_idx_q      <= '0;
      col_count_o    <= '0;
      row_count_o    <= '0;
      cell_valid_o   <= 1'b0;
      cell_rop_o     <= 1'b0;
      cell_last_o    <= 1'b0;
      grid_done_o    <= 1'b0;
      format_error_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      pcell_q        <= pcell_d;
      col_idx_q      <= col_idx_d;
      col_count_o    <= col_count_d;
      row_count_o    <= row_count_d;
      cell_valid_o   <= cell_valid_d;
      cell_rop_o     <= cell_rop_d;
      cell_last_o    <= cell_last_d;
      grid_done_o    <= grid_done_d;
      format_error_o <= format_error_d;
    end
  always_comb
    state_d = !g               ? state_q  :
              bad              ? ST_ERROR :
              term_ok          ? ST_DONE  :
              eol_ok && first  ? ST_ROW   : state_q;
  always_comb begin
    cell_valid_d   = g && ((cell_ok && pend_q) || eol_ok);
    cell_rop_d     = cell_valid_d && pcell_q;
    cell_last_d    = g && eol_ok;
    grid_done_d    = g && term_ok;
    format_error_d = format_error_o || bad;
    pend_d         = g && cell_ok ? 1'b1 : g && (eol_ok || bad) ? 1'b0 : pend_q;
    pcell_d        = g && cell_ok ? cls == CLS_CELL1 : pcell_q;
    col_idx_d      = g && cell_ok ? col_idx_q + 1'b1 : g && eol_ok ? '0 : col_idx_q;
    col_count_d    = g && eol_ok && first ? col_idx_q : col_count_o;
    row_count_d    = g && eol_ok ? row_count_o + 1'b1 : row_count_o;
  end
endmodule

// File: tb/tb_grid_row_framer.sv
// tb_grid_row_framer: table-driven and directed checks of grid_row_framer
module tb_grid_row_framer;
  logic clk = 1'b0, rst_n = 1'b0, byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic cell_valid, cell_rop, cell_last, grid_done, format_error;
  logic [7:0] col_count, row_count;
  int tests = 0, fails = 0, n = 0;
  typedef struct packed {
    logic       rs;
    logic       vb;
    logic [7:0] b;
    logic [4:0] fl;
    logic [7:0] cc;
    logic [7:0] rc;
  } vec_t;
  vec_t tab[64];
  always #5 clk = ~clk;
  grid_row_framer dut (
    .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .cell_valid_o(cell_valid), .cell_rop_o(cell_rop), .cell_last_o(cell_last),
    .grid_done_o(grid_done), .col_count_o(col_count), .row_count_o(row_count),
    .format_error_o(format_error)
  );
  task automatic add(input bit rs, input bit vb, input logic [7:0] b, input logic [4:0] fl,
                     input int cc, input int rc);
    tab[n] = '{rs, vb, b, fl, 8'(cc), 8'(rc)};
    n++;
  endtask
  task automatic chk(input string nm, input logic [20:0] got, input logic [20:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask
  function automatic logic [20:0] outs();
    return {cell_valid, cell_rop, cell_last, grid_done, format_error, col_count, row_count};
  endfunction
  task automatic do_reset();
    byte_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data = b;
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask
  int cells, lasts;
  initial begin
    // fl = {valid, rop, last, done, error}
    add(1, 1, "@",  5'b00000, 0, 0);
    add(0, 1, ".",  5'b11000, 0, 0);
    add(0, 1, "@",  5'b10000, 0, 0);
    add(0, 1, 8'h0A,5'b11100, 3, 1);
    add(0, 1, ".",  5'b00000, 3, 1);
    add(0, 1, "@",  5'b10000, 3, 1);
    add(0, 1, "@",  5'b11000, 3, 1);
    add(0, 1, 8'h0A,5'b11100, 3, 2);
    add(0, 1, 8'h00,5'b00010, 3, 2);
    add(0, 0, 8'h00,5'b00000, 3, 2);
    add(0, 1, "@",  5'b00000, 3, 2);
    add(1, 1, "@",  5'b00000, 0, 0);
    add(0, 1, "@",  5'b11000, 0, 0);
    add(0, 1, 8'h0D,5'b00000, 0, 0);
    add(0, 1, 8'h0A,5'b11100, 2, 1);
    add(0, 1, ".",  5'b00000, 2, 1);
    add(0, 1, "@",  5'b10000, 2, 1);
    add(0, 1, 8'h0D,5'b00000, 2, 1);
    add(0, 1, 8'h0A,5'b11100, 2, 2);
    add(0, 1, 8'h0A,5'b00010, 2, 2);
    add(1, 1, "@",  5'b00000, 0, 0);
    add(0, 1, "@",  5'b11000, 0, 0);
    add(0, 1, "@",  5'b11000, 0, 0);
    add(0, 1, 8'h0A,5'b11100, 3, 1);
    add(0, 1, "@",  5'b00000, 3, 1);
    add(0, 1, "@",  5'b11000, 3, 1);
    add(0, 1, 8'h0A,5'b00001, 3, 1);
    add(0, 1, 8'h00,5'b00001, 3, 1);
    add(1, 1, "@",  5'b00000, 0, 0);
    add(0, 1, ".",  5'b11000, 0, 0);
    add(0, 1, 8'h0A,5'b10100, 2, 1);
    add(0, 1, "@",  5'b00000, 2, 1);
    add(0, 1, ".",  5'b11000, 2, 1);
    add(0, 1, "@",  5'b00001, 2, 1);
    add(0, 1, 8'h00,5'b00001, 2, 1);
    add(0, 1, "@",  5'b00001, 2, 1);
    add(1, 1, "@",  5'b00000, 0, 0);
    add(0, 1, "x",  5'b00001, 0, 0);
    add(0, 1, 8'h0A,5'b00001, 0, 0);
    add(1, 1, 8'h00,5'b00010, 0, 0);
    add(0, 1, 8'h00,5'b00000, 0, 0);
    do_reset();
    chk("reset_state", outs(), 21'h0);
    for (int i = 0; i < n; i++) begin
      if (tab[i].rs) do_reset();
      byte_valid = tab[i].vb;
      byte_data = tab[i].b;
      @(posedge clk);
      #1 byte_valid = 1'b0;
      chk($sformatf("vec%0d", i), outs(), {tab[i].fl, tab[i].cc, tab[i].rc});
    end
    do_reset();
    cells = 0;
    lasts = 0;
    for (int i = 1; i <= 161; i++) begin
      send("@");
      cells += int'(cell_valid);
      lasts += int'(cell_last);
      if (i == 160) chk("long_no_err_160", 21'(format_error), 21'd0);
    end
    chk("long_err_161", 21'(format_error), 21'd1);
    chk("long_cells", 21'(cells), 21'd159);
    chk("long_lasts", 21'(lasts), 21'd0);
    send("@");
    send("@");
    byte_valid = 1'b1;
    byte_data = "@";
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 21'h0);
    @(posedge clk);
    #1 chk("reset_held", outs(), 21'h0);
    rst_n = 1'b1;
    byte_valid = 1'b0;
    send("@");
    chk("post_rst_at", outs(), 21'h0);
    send(8'h0A);
    chk("post_rst_lf", outs(), {5'b11100, 8'd1, 8'd1});
    send(8'h00);
    chk("post_rst_nul", outs(), {5'b00010, 8'd1, 8'd1});
    @(posedge clk);
    #1 chk("done_pulse_one", outs(), {5'b00000, 8'd1, 8'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
